mem_bus_arbiter: RTL and testbench

//  Shares the single core-side memory bus between the instruction-fetch requester (IF stage)
//  and the load/store requester (MEM stage). Registered single-beat arbitration; owner holds grant

---
 rtl/mem_bus_arbiter_pkg.sv | 21 ++
 rtl/mem_bus_arbiter.sv | 85 ++++++++
 tb/tb_mem_bus_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared bus encodings and arbiter state type for the core memory bus.
package mem_bus_arbiter_pkg;

    localparam int INST_ADDR_BUS = 64;
    localparam int DATA_BUS      = 64;

    localparam logic [1:0] SIZE_BYTE  = 2'd0;
    localparam logic [1:0] SIZE_HALF  = 2'd1;
    localparam logic [1:0] SIZE_WORD  = 2'd2;
    localparam logic [1:0] SIZE_DWORD = 2'd3;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GNT_IF  = 2'd1,
        ARB_GNT_MEM = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the core memory bus between IF and MEM with registered grant and IF anti-starvation.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W     = INST_ADDR_BUS,
    parameter int DATA_W     = DATA_BUS,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic [1:0]        if_size_i,
    input  logic              if_req_i,
    output logic              if_ready_o,
    output logic [DATA_W-1:0] if_data_read_o,
    output logic [1:0]        if_resp_o,
    input  logic              mem_valid_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [1:0]        mem_size_i,
    input  logic              mem_req_i,
    input  logic [DATA_W-1:0] mem_data_write_i,
    output logic              mem_ready_o,
    output logic [DATA_W-1:0] mem_data_read_o,
    output logic [1:0]        mem_resp_o,
    output logic              bus_valid_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [1:0]        bus_size_o,
    output logic              bus_req_o,
    output logic [DATA_W-1:0] bus_data_write_o,
    input  logic              bus_ready_i,
    input  logic [DATA_W-1:0] bus_data_read_i,
    input  logic [1:0]        bus_resp_i
);

    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

    arb_state_e     state, state_nxt;
    logic [SW-1:0]  streak, streak_nxt;
    logic           if_own, mem_own, done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ARB_IDLE;
            streak <= '0;
        end else begin
            state  <= state_nxt;
            streak <= streak_nxt;
        end
    end

    // Owner's request is passed straight through; a dropped valid withdraws it the same cycle.
    always_comb begin
        if_own           = state == ARB_GNT_IF;
        mem_own          = state == ARB_GNT_MEM;
        bus_valid_o      = (if_own & if_valid_i) | (mem_own & mem_valid_i);
        bus_addr_o       = if_own ? if_addr_i : mem_own ? mem_addr_i : '0;
        bus_size_o       = if_own ? if_size_i : mem_own ? mem_size_i : '0;
        bus_req_o        = if_own ? if_req_i  : mem_own ? mem_req_i  : 1'b0;
        bus_data_write_o = mem_own ? mem_data_write_i : '0;
        done             = bus_valid_o & bus_ready_i;
        if_ready_o       = if_own & done;
        mem_ready_o      = mem_own & done;
        if_data_read_o   = if_ready_o  ? bus_data_read_i : '0;
        if_resp_o        = if_ready_o  ? bus_resp_i      : '0;
        mem_data_read_o  = mem_ready_o ? bus_data_read_i : '0;
        mem_resp_o       = mem_ready_o ? bus_resp_i      : '0;
    end

    // MEM wins ties unless IF has already waited through MAX_STREAK MEM completions.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:    state_nxt = (mem_valid_i && !(if_valid_i && streak == STREAK_MAX)) ? ARB_GNT_MEM :
                                     if_valid_i ? ARB_GNT_IF : ARB_IDLE;
            ARB_GNT_IF:  state_nxt = (!if_valid_i || bus_ready_i) ? ARB_IDLE : ARB_GNT_IF;
            ARB_GNT_MEM: state_nxt = (!mem_valid_i || bus_ready_i) ? ARB_IDLE : ARB_GNT_MEM;
            default:     state_nxt = ARB_IDLE;
        endcase
        streak_nxt = (!if_valid_i || if_ready_o) ? '0 :
                     (mem_ready_o && streak != STREAK_MAX) ? streak + SW'(1) : streak;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed stimulus with a response scoreboard for the IF/MEM bus arbiter.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid_i, if_req_i, if_ready_o;
    logic [63:0] if_addr_i, if_data_read_o;
    logic [1:0]  if_size_i, if_resp_o;
    logic        mem_valid_i, mem_req_i, mem_ready_o;
    logic [63:0] mem_addr_i, mem_data_write_i, mem_data_read_o;
    logic [1:0]  mem_size_i, mem_resp_o;
    logic        bus_valid_o, bus_req_o, bus_ready_i;
    logic [63:0] bus_addr_o, bus_data_write_o, bus_data_read_i;
    logic [1:0]  bus_size_o, bus_resp_i;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t if_q[$];
    exp_t mem_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   if_cnt   = 0;
    int   mem_cnt  = 0;
    int   mem_base;
    bit   mon_on   = 1'b0;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .if_valid_i(if_valid_i), .if_addr_i(if_addr_i), .if_size_i(if_size_i), .if_req_i(if_req_i),
        .if_ready_o(if_ready_o), .if_data_read_o(if_data_read_o), .if_resp_o(if_resp_o),
        .mem_valid_i(mem_valid_i), .mem_addr_i(mem_addr_i), .mem_size_i(mem_size_i), .mem_req_i(mem_req_i),
        .mem_data_write_i(mem_data_write_i), .mem_ready_o(mem_ready_o),
        .mem_data_read_o(mem_data_read_o), .mem_resp_o(mem_resp_o),
        .bus_valid_o(bus_valid_o), .bus_addr_o(bus_addr_o), .bus_size_o(bus_size_o), .bus_req_o(bus_req_o),
        .bus_data_write_o(bus_data_write_o), .bus_ready_i(bus_ready_i),
        .bus_data_read_i(bus_data_read_i), .bus_resp_i(bus_resp_i)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bus(input string tag);
        for (int i = 0; i < 20 && bus_valid_o !== 1'b1; i++) tick();
        check(tag, bus_valid_o, 1);
    endtask

    // Drive a downstream completion and record which requester must receive it.
    task automatic respond(input bit to_if, input logic [63:0] data, input logic [1:0] resp, input int lat);
        exp_t e;
        repeat (lat) tick();
        e.data = data;
        e.resp = resp;
        if (to_if) if_q.push_back(e);
        else mem_q.push_back(e);
        bus_ready_i     = 1'b1;
        bus_data_read_i = data;
        bus_resp_i      = resp;
        tick();
        bus_ready_i     = 1'b0;
        bus_data_read_i = '0;
        bus_resp_i      = '0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_on) begin
            if (if_ready_o) begin
                if_cnt++;
                if (if_q.size() == 0) check("if_unexpected_ready", 1, 0);
                else begin
                    e = if_q.pop_front();
                    check("if_data", if_data_read_o, e.data);
                    check("if_resp", 64'(if_resp_o), 64'(e.resp));
                end
            end else begin
                check("if_data_idle", if_data_read_o, 0);
                check("if_resp_idle", 64'(if_resp_o), 0);
            end
            if (mem_ready_o) begin
                mem_cnt++;
                if (mem_q.size() == 0) check("mem_unexpected_ready", 1, 0);
                else begin
                    e = mem_q.pop_front();
                    check("mem_data", mem_data_read_o, e.data);
                    check("mem_resp", 64'(mem_resp_o), 64'(e.resp));
                end
            end else begin
                check("mem_data_idle", mem_data_read_o, 0);
                check("mem_resp_idle", 64'(mem_resp_o), 0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        if_valid_i = 1'b1; if_addr_i = '0; if_size_i = SIZE_WORD; if_req_i = REQ_READ;
        mem_valid_i = 1'b1; mem_addr_i = '0; mem_size_i = SIZE_DWORD; mem_req_i = REQ_READ;
        mem_data_write_i = '0;
        bus_ready_i = 1'b0; bus_data_read_i = '0; bus_resp_i = '0;

        repeat (3) begin
            tick();
            check("rst_bus_valid", bus_valid_o, 0);
            check("rst_if_ready", if_ready_o, 0);
            check("rst_mem_ready", mem_ready_o, 0);
            check("rst_state", dut.state, ARB_IDLE);
        end
        if_valid_i = 1'b0;
        mem_valid_i = 1'b0;
        rst = 1'b0;
        mon_on = 1'b1;
        tick();

        // IF alone: grant one cycle after request, response two cycles into the grant
        if_addr_i = 64'h8000_0000;
        if_valid_i = 1'b1;
        check("if_arb_latency", bus_valid_o, 0);
        wait_bus("if_grant");
        check("if_bus_addr", bus_addr_o, 64'h8000_0000);
        check("if_bus_req", bus_req_o, REQ_READ);
        check("if_bus_wdata_zero", bus_data_write_o, 0);
        respond(1'b1, 64'h13, 2'b00, 2);
        check("if_ready_one_cycle", if_ready_o, 0);
        check("if_cnt", if_cnt, 1);
        if_valid_i = 1'b0;
        tick();

        // Simultaneous requests: MEM store first, then IF after an IDLE cycle
        mem_addr_i = 64'h8000_1000; mem_req_i = REQ_WRITE; mem_data_write_i = 64'hDEAD;
        if_addr_i = 64'h8000_0040;
        mem_valid_i = 1'b1;
        if_valid_i = 1'b1;
        wait_bus("tie_grant");
        check("tie_mem_addr", bus_addr_o, 64'h8000_1000);
        check("tie_mem_wdata", bus_data_write_o, 64'hDEAD);
        check("tie_mem_req", bus_req_o, REQ_WRITE);
        check("tie_mem_size", 64'(bus_size_o), 64'(SIZE_DWORD));
        respond(1'b0, 64'h0, 2'b00, 0);
        mem_valid_i = 1'b0;
        check("tie_idle_gap", bus_valid_o, 0);
        check("tie_idle_state", dut.state, ARB_IDLE);
        tick();
        check("tie_if_grant", bus_valid_o, 1);
        check("tie_if_addr", bus_addr_o, 64'h8000_0040);
        check("tie_if_wdata_zero", bus_data_write_o, 0);
        respond(1'b1, 64'h0000_0297, 2'b01, 1);
        if_valid_i = 1'b0;
        tick();

        // Continuous MEM with IF waiting: exactly MAX_STREAK MEM completions, then IF
        mem_addr_i = 64'h8000_2000; mem_req_i = REQ_READ; mem_data_write_i = '0;
        if_addr_i = 64'h8000_0080;
        mem_base = mem_cnt;
        mem_valid_i = 1'b1;
        if_valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_bus("streak_mem_grant");
            check("streak_mem_owner", bus_addr_o, 64'h8000_2000);
            respond(1'b0, 64'h100 + 64'(k), 2'b00, 0);
        end
        wait_bus("streak_if_grant");
        check("streak_if_forced", bus_addr_o, 64'h8000_0080);
        check("streak_mem_count", mem_cnt - mem_base, 4);
        respond(1'b1, 64'h55, 2'b00, 0);
        check("streak_cleared", 64'(dut.streak), 0);
        mem_valid_i = 1'b0;
        if_valid_i = 1'b0;
        tick();

        // IF withdraws before completion; late bus_ready in IDLE must be ignored
        if_addr_i = 64'h8000_00C0;
        if_valid_i = 1'b1;
        wait_bus("wd_grant");
        tick();
        if_valid_i = 1'b0;
        #1;
        check("wd_bus_valid_drop", bus_valid_o, 0);
        check("wd_no_ready", if_ready_o, 0);
        tick();
        check("wd_idle", dut.state, ARB_IDLE);
        bus_ready_i = 1'b1;
        bus_data_read_i = 64'hBAD;
        #1;
        check("late_ready_if", if_ready_o, 0);
        check("late_ready_mem", mem_ready_o, 0);
        check("late_ready_bus_valid", bus_valid_o, 0);
        tick();
        check("late_ready_state", dut.state, ARB_IDLE);
        bus_ready_i = 1'b0;
        bus_data_read_i = '0;

        // Reset in the middle of a MEM grant, then a normal re-request
        mem_addr_i = 64'h8000_3000; mem_req_i = REQ_WRITE; mem_data_write_i = 64'hBEEF;
        mem_valid_i = 1'b1;
        wait_bus("rstmid_grant");
        rst = 1'b1;
        tick();
        check("rstmid_bus_valid", bus_valid_o, 0);
        check("rstmid_bus_addr", bus_addr_o, 0);
        check("rstmid_bus_wdata", bus_data_write_o, 0);
        check("rstmid_mem_ready", mem_ready_o, 0);
        check("rstmid_state", dut.state, ARB_IDLE);
        rst = 1'b0;
        tick();
        check("rerequest_grant", bus_valid_o, 1);
        check("rerequest_addr", bus_addr_o, 64'h8000_3000);
        respond(1'b0, 64'h77, 2'b10, 1);
        mem_valid_i = 1'b0;
        tick();
        tick();

        check("if_queue_drained", if_q.size(), 0);
        check("mem_queue_drained", mem_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
